// File: rtl/i2s_tx_gen.sv
// rtl/i2s_tx_gen.sv - I2S transmitter with one-entry pending register and bit-clock divider.
// Define I2S_TX_HOLD_ON_UNDERRUN_EN to retransmit the last pair on underrun instead of sending silence.
module i2s_tx_gen #(
  parameter int BCK_HALF = 2,
  parameter int WIDTH    = 24
) (
  input  logic             mck_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] l_data_i,
  input  logic [WIDTH-1:0] r_data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             bck_o,
  output logic             lrck_o,
  output logic             data_o,
  output logic             underrun_o
);

  localparam int            DW     = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam logic [DW-1:0] DIV_TC = DW'(BCK_HALF - 1);
  localparam logic [4:0]    W5     = 5'(WIDTH);

  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             bck_q, bck_d;
  logic             lrck_q, lrck_d;
  logic             data_q, data_d;
  logic             underrun_q, underrun_d;
  logic             pend_v_q, pend_v_d;
  logic [WIDTH-1:0] pend_l_q, pend_l_d;
  logic [WIDTH-1:0] pend_r_q, pend_r_d;
  logic [WIDTH-1:0] frm_l_q, frm_l_d;
  logic [WIDTH-1:0] frm_r_q, frm_r_d;

  logic             tc;
  logic             fall;
  logic             accept;
  logic [5:0]       bit_nxt;
  logic [4:0]       slot;
  logic [WIDTH-1:0] cur_word;
  logic [WIDTH-1:0] bit_mask;

  always_comb begin
    tc         = (div_cnt_q == DIV_TC);
    fall       = 1'b0;
    accept     = 1'b0;
    bit_nxt    = bit_cnt_q + 6'd1;
    slot       = bit_nxt[4:0];
    cur_word   = bit_nxt[5] ? frm_r_q : frm_l_q;
    bit_mask   = WIDTH'(1) << (W5 - slot);

    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    bck_d      = bck_q;
    lrck_d     = lrck_q;
    data_d     = data_q;
    underrun_d = 1'b0;
    pend_v_d   = pend_v_q;
    pend_l_d   = pend_l_q;
    pend_r_d   = pend_r_q;
    frm_l_d    = frm_l_q;
    frm_r_d    = frm_r_q;

    if (!en_i) begin
      div_cnt_d = '0;
      bit_cnt_d = 6'd63;
      bck_d     = 1'b0;
      lrck_d    = 1'b0;
      data_d    = 1'b0;
    end else begin
      // ready is judged on the registered pend_v, so a frame-start clear never admits a pair
      accept    = valid_i && !pend_v_q;
      div_cnt_d = tc ? '0 : div_cnt_q + DW'(1);
      if (tc) bck_d = !bck_q;
      fall = tc && bck_q;
      if (fall) begin
        bit_cnt_d = bit_nxt;
        lrck_d    = bit_nxt[5];
        data_d    = (slot != 5'd0 && slot <= W5) ? |(cur_word & bit_mask) : 1'b0;
        if (bit_cnt_q == 6'd63) begin
          if (pend_v_q) begin
            frm_l_d  = pend_l_q;
            frm_r_d  = pend_r_q;
            pend_v_d = 1'b0;
          end else begin
            underrun_d = 1'b1;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
            frm_l_d = frm_l_q;
            frm_r_d = frm_r_q;
`else
            frm_l_d = '0;
            frm_r_d = '0;
`endif
          end
        end
      end
      if (accept) begin
        pend_l_d = l_data_i;
        pend_r_d = r_data_i;
        pend_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge mck_i) begin
    if (rst_i) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= 6'd63;
      bck_q      <= 1'b0;
      lrck_q     <= 1'b0;
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_l_q   <= '0;
      pend_r_q   <= '0;
      frm_l_q    <= '0;
      frm_r_q    <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bck_q      <= bck_d;
      lrck_q     <= lrck_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      pend_v_q   <= pend_v_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      frm_l_q    <= frm_l_d;
      frm_r_q    <= frm_r_d;
    end
  end

  assign ready_o    = !pend_v_q;
  assign bck_o      = bck_q;
  assign lrck_o     = lrck_q;
  assign data_o     = data_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx_gen.sv
// tb/tb_i2s_tx_gen.sv - self-checking bench for i2s_tx_gen against a frame-level reference model.
module tb_i2s_tx_gen;
  localparam int BH = 2;
  localparam int W  = 24;

  logic         mck = 1'b0;
  logic         rst, en, valid;
  logic [W-1:0] l_d, r_d;
  logic         ready, bck, lrck, dat, ur;

  int errors = 0;
  int checks = 0;

  i2s_tx_gen #(.BCK_HALF(BH), .WIDTH(W)) dut (
    .mck_i(mck), .rst_i(rst), .en_i(en), .l_data_i(l_d), .r_data_i(r_d),
    .valid_i(valid), .ready_o(ready), .bck_o(bck), .lrck_o(lrck),
    .data_o(dat), .underrun_o(ur)
  );

  always #5 mck = ~mck;

  // Model: k counts enabled edges; bck, bit position follow from k by division.
  int k;
  int m_bc;
  bit m_bck, m_lrck, m_data, m_ur, m_pv, m_fall;
  int m_pl, m_pr, m_fl, m_fr;
  logic [W-1:0] cap_l, cap_r;
  int ur_cnt;

  task automatic model_edge();
    bit acc;
    int p, word;
    m_fall = 1'b0;
    if (rst) begin
      k = 0; m_bc = 63; m_bck = 0; m_lrck = 0; m_data = 0; m_ur = 0;
      m_pv = 0; m_pl = 0; m_pr = 0; m_fl = 0; m_fr = 0;
    end else if (!en) begin
      k = 0; m_bc = 63; m_bck = 0; m_lrck = 0; m_data = 0; m_ur = 0;
    end else begin
      acc  = valid && !m_pv;
      k    = k + 1;
      m_ur = 0;
      if (k % BH == 0) begin
        m_bck = ((k / BH) % 2) == 1;
        if (!m_bck) begin
          m_fall = 1'b1;
          m_bc   = (63 + k / (2 * BH)) % 64;
          m_lrck = (m_bc >= 32);
          if (m_bc == 0) begin
            if (m_pv) begin
              m_fl = m_pl; m_fr = m_pr; m_pv = 0;
            end else begin
              m_ur = 1;
`ifndef I2S_TX_HOLD_ON_UNDERRUN_EN
              m_fl = 0; m_fr = 0;
`endif
            end
          end
          p    = m_bc % 32;
          word = m_lrck ? m_fr : m_fl;
          m_data = (p >= 1 && p <= W) ? bit'((word >> (W - p)) & 1) : 1'b0;
        end
      end
      if (acc) begin
        m_pv = 1; m_pl = int'(l_d); m_pr = int'(r_d);
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0b expected=%0b", tag, k, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge mck);
    model_edge();
    #1;
    check_bit("bck", bck, m_bck);
    check_bit("lrck", lrck, m_lrck);
    check_bit("data", dat, m_data);
    check_bit("underrun", ur, m_ur);
    check_bit("ready", ready, !m_pv);
    if (ur) ur_cnt++;
    if (m_fall) begin
      if (m_bc == 0) begin
        cap_l = '0; cap_r = '0;
      end else if (m_bc <= W) begin
        cap_l = {cap_l[W-2:0], dat};
      end else if (m_bc >= 33 && m_bc <= 32 + W) begin
        cap_r = {cap_r[W-2:0], dat};
      end
    end
  endtask

  task automatic wait_bc(input int target);
    int n;
    n = 0;
    while (!(m_fall && m_bc == target) && n < 800) begin
      l_d = W'($urandom); r_d = W'($urandom);
      cycle();
      n++;
    end
    check_int("wait_bc_timeout", n < 800 ? 1 : 0, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; l_d = '0; r_d = '0;
    cap_l = '0; cap_r = '0; ur_cnt = 0;
    cycle();
    cycle();
    check_bit("rst_ready", ready, 1'b1);
    check_bit("rst_bck", bck, 1'b0);
    check_bit("rst_data", dat, 1'b0);
    rst = 1'b0;
    cycle();

    // enable with a pair offered on the same edge; it is loaded at the first frame start
    en = 1'b1; valid = 1'b1; l_d = 24'h800001; r_d = 24'h7FFFFE;
    cycle();
    valid = 1'b0; l_d = '0; r_d = '0;
    repeat (257) cycle();
    check_int("frame1_left", int'(cap_l), 32'h800001);
    check_int("frame1_right", int'(cap_r), 32'h7FFFFE);

    ur_cnt = 0;
    repeat (512) cycle();
    check_int("underrun_count", ur_cnt, 2);
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
    check_int("frame3_left", int'(cap_l), 32'h800001);
    check_int("frame3_right", int'(cap_r), 32'h7FFFFE);
`else
    check_int("frame3_left", int'(cap_l), 0);
    check_int("frame3_right", int'(cap_r), 0);
`endif

    valid = 1'b1;
    for (int i = 0; i < 3 * 256; i++) begin
      l_d = W'($urandom); r_d = W'($urandom);
      cycle();
    end

    wait_bc(40);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      l_d = W'($urandom); r_d = W'($urandom);
      cycle();
    end
    en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      valid = 1'($urandom_range(0, 1));
      l_d = W'($urandom); r_d = W'($urandom);
      cycle();
    end

    valid = 1'b1;
    wait_bc(45);
    rst = 1'b1;
    cycle();
    check_bit("midrst_ready", ready, 1'b1);
    check_bit("midrst_lrck", lrck, 1'b0);
    check_bit("midrst_underrun", ur, 1'b0);
    rst = 1'b0; valid = 1'b0;
    ur_cnt = 0;
    repeat (300) cycle();
    check_int("post_rst_underrun", ur_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
